// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, default line settings and baud divider helper
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ  = 100_000_000;
    localparam int unsigned DEF_BAUD_RATE = 9600;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_state_e;

    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an idle-high asynchronous pin
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic m;

    always_ff @(posedge clk) begin
        if (rst) begin
            m <= 1'b1;
            q <= 1'b1;
        end else begin
            m <= d;
            q <= m;
        end
    end

endmodule

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with framing-error strobe; define UART_PARITY_EN for 8E1 with parity_err
module uart_recv
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
    parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int unsigned BAUD_DIV  = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_DIV  = BAUD_DIV / 2;
    localparam logic [13:0] BIT_LAST  = 14'(BAUD_DIV - 1);
    localparam logic [13:0] HALF_LAST = 14'(HALF_DIV - 1);

`ifdef UART_PARITY_EN
    localparam uart_state_e AFTER_DATA = ST_PARITY;
`else
    localparam uart_state_e AFTER_DATA = ST_STOP;
`endif

    uart_state_e state;
    logic [13:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shift;
    logic        din_s;
    logic        din_d;
    logic        fall;
    logic        bit_end;
    logic        good;

    uart_sync2 u_sync (
        .clk(clk),
        .rst(rst),
        .d  (din),
        .q  (din_s)
    );

`ifdef UART_PARITY_EN
    logic par_bit;
    logic par_err_r;
    assign parity_err = par_err_r;
    always_comb good = (par_bit == ^shift);
`else
    assign parity_err = 1'b0;
    always_comb good = 1'b1;
`endif

    always_comb begin
        fall    = din_d & ~din_s;
        bit_end = (cnt == BIT_LAST);
        busy    = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            din_d     <= 1'b1;
`ifdef UART_PARITY_EN
            par_bit   <= 1'b0;
            par_err_r <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            din_d     <= din_s;
            cnt       <= cnt + 14'd1;
`ifdef UART_PARITY_EN
            par_err_r <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (fall) state <= ST_START;
                end
                ST_START: if (cnt == HALF_LAST) begin
                    cnt   <= '0;
                    idx   <= '0;
                    state <= din_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: if (bit_end) begin
                    cnt        <= '0;
                    shift[idx] <= din_s;
                    idx        <= idx + 3'd1;
                    if (idx == 3'd7) state <= AFTER_DATA;
                end
`ifdef UART_PARITY_EN
                ST_PARITY: if (bit_end) begin
                    cnt     <= '0;
                    par_bit <= din_s;
                    state   <= ST_STOP;
                end
`endif
                ST_STOP: if (bit_end) begin
                    cnt <= '0;
                    if (!din_s) begin
                        frame_err <= 1'b1;
                        state     <= ST_WAIT_HIGH;
                    end else begin
                        state <= ST_IDLE;
                        if (good) begin
                            data  <= shift;
                            valid <= 1'b1;
                        end
`ifdef UART_PARITY_EN
                        else par_err_r <= 1'b1;
`endif
                    end
                end
                ST_WAIT_HIGH: begin
                    cnt <= '0;
                    if (din_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: scoreboard bench for uart_recv at a scaled-down baud divider of 16
module tb_uart_recv;

    localparam int CF = 1_600_000;
    localparam int BR = 100_000;
    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    typedef struct {
        int         kind;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic pv = 1'b0;

    uart_recv #(.CLK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        din = b;
        repeat (BD) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid | frame_err | parity_err) begin
                check("strobe_exclusive", $countones({valid, frame_err, parity_err}), 1);
                if (sb.size() == 0) begin
                    check("unexpected_strobe", valid ? 0 : frame_err ? 1 : 2, -1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("strobe_kind", valid ? 0 : frame_err ? 1 : 2, e.kind);
                    check("data", int'(data), int'(e.d));
                    if (valid) begin
                        check("busy_at_valid", int'(busy), 0);
                        check("valid_width", int'(pv), 0);
                    end
                end
            end
            pv = valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_parity_err", int'(parity_err), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back('{0, 8'h55});
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                int n = 0;
                while (!valid && n < 400) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("latency_0x55", n, 155);
            end
        join
        send_bit(1'b1);
        sb.push_back('{0, 8'h00});
        sb.push_back('{0, 8'hFF});
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_bit(1'b1);
        din = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("glitch_busy_high", int'(busy), 1);
        din = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("glitch_busy_low", int'(busy), 0);
        send_bit(1'b1);
        sb.push_back('{1, 8'hFF});
        send_frame(8'hA3, 1'b0, 1'b0);
        din = 1'b0;
        repeat (320) @(posedge clk);
        #1;
        din = 1'b1;
        send_bit(1'b1);
        sb.push_back('{0, 8'h3C});
        send_frame(8'h3C, 1'b1, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        din = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_data", int'(data), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_frame_err", int'(frame_err), 0);
        check("midrst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        din = 1'b1;
        rst = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        sb.push_back('{0, 8'h42});
        send_frame(8'h42, 1'b1, 1'b0);
        send_bit(1'b1);
`ifdef UART_PARITY_EN
        sb.push_back('{0, 8'h07});
        send_frame(8'h07, 1'b1, 1'b0);
        send_bit(1'b1);
        sb.push_back('{2, 8'h07});
        send_frame(8'h07, 1'b1, 1'b1);
        send_bit(1'b1);
`endif
        send_bit(1'b1);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
